// File: rtl/uart_rx_packet_ctrl.sv
// Packet framer behind the UART RX byte controller: hunts SYNC, sequences LEN/payload/CSUM,
// streams payload through a small ready/valid FIFO and flags completion, faults and timeouts.
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         MAX_LEN    = 16,
    parameter int         TIMEOUT    = 1000,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_Rx_Done,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Pay_Valid,
    output logic [7:0] o_Pay_Byte,
    input  logic       i_Pay_Ready,
    output logic       o_Pkt_Active,
    output logic       o_Pkt_Done,
    output logic       o_Pkt_Err,
    output logic [1:0] o_Err_Code
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);

    localparam logic [1:0] ERR_CSUM    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CSUM    = 2'd3
    } state_t;

    state_t          r_state;
    logic [7:0]      r_sum;
    logic [7:0]      r_remaining;
    logic [CW-1:0]   r_tmo;
    logic            r_active;
    logic            r_pkt_done;
    logic            r_pkt_err;
    logic [1:0]      r_err_code;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [NW-1:0]   r_count;
    logic            r_pay_valid;
    logic [7:0]      r_pay_byte;

    logic            w_pop;
    logic            w_full;
    logic            w_pay_byte_in;
    logic            w_push;
    logic            w_overrun;
    logic [NW-1:0]   w_count_next;
    logic [PW-1:0]   w_rd_ptr_next;
    logic [7:0]      w_head_next;

    assign w_pop         = r_pay_valid & i_Pay_Ready;
    assign w_full        = (r_count == FIFO_FULL);
    assign w_pay_byte_in = i_Rx_Done & (r_state == S_PAYLOAD);
    assign w_push        = w_pay_byte_in & (~w_full | w_pop);
    assign w_overrun     = w_pay_byte_in & w_full & ~w_pop;

    // Next FIFO occupancy, read pointer and head byte, so the outputs can be registered.
    always_comb begin
        w_count_next  = r_count;
        w_rd_ptr_next = r_rd_ptr;
        w_head_next   = 8'd0;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + NW'(1);
            2'b01:   w_count_next = r_count - NW'(1);
            default: w_count_next = r_count;
        endcase
        if (w_pop) begin
            w_rd_ptr_next = r_rd_ptr + PW'(1);
        end else begin
            w_rd_ptr_next = r_rd_ptr;
        end
        // A push landing on the new read slot means the FIFO was draining to empty.
        if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
            w_head_next = i_Rx_Byte;
        end else begin
            w_head_next = r_mem[w_rd_ptr_next];
        end
    end

    // Payload FIFO storage, pointers and registered head presentation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pay_valid <= 1'b0;
            r_pay_byte  <= 8'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_Rx_Byte;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_pay_valid <= (w_count_next != '0);
            r_pay_byte  <= w_head_next;
        end
    end

    // Frame sequencer with inter-byte timeout; a received byte always beats the timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_HUNT;
            r_sum       <= 8'd0;
            r_remaining <= 8'd0;
            r_tmo       <= '0;
            r_active    <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_pkt_done <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_code <= 2'd0;
            if (i_Rx_Done) begin
                r_tmo <= '0;
                case (r_state)
                    S_HUNT: begin
                        if (i_Rx_Byte == SYNC_BYTE) begin
                            r_state  <= S_LEN;
                            r_active <= 1'b1;
                        end
                    end
                    S_LEN: begin
                        if (i_Rx_Byte == 8'd0) begin
                            r_sum   <= 8'd0;
                            r_state <= S_CSUM;
                        end else if (i_Rx_Byte > MAX_LEN_B) begin
                            r_pkt_err  <= 1'b1;
                            r_err_code <= ERR_LEN;
                            r_state    <= S_HUNT;
                            r_active   <= 1'b0;
                        end else begin
                            r_sum       <= i_Rx_Byte;
                            r_remaining <= i_Rx_Byte;
                            r_state     <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_overrun) begin
                            r_pkt_err  <= 1'b1;
                            r_err_code <= ERR_OVERRUN;
                            r_state    <= S_HUNT;
                            r_active   <= 1'b0;
                        end else begin
                            r_sum       <= r_sum + i_Rx_Byte;
                            r_remaining <= r_remaining - 8'd1;
                            if (r_remaining == 8'd1) begin
                                r_state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (i_Rx_Byte == r_sum) begin
                            r_pkt_done <= 1'b1;
                        end else begin
                            r_pkt_err  <= 1'b1;
                            r_err_code <= ERR_CSUM;
                        end
                        r_state  <= S_HUNT;
                        r_active <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_HUNT;
                        r_active <= 1'b0;
                    end
                endcase
            end else if (r_state == S_HUNT) begin
                r_tmo <= '0;
            end else if (r_tmo == TMO_LAST) begin
                r_pkt_err  <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
                r_state    <= S_HUNT;
                r_active   <= 1'b0;
                r_tmo      <= '0;
            end else begin
                r_tmo <= r_tmo + CW'(1);
            end
        end
    end

    assign o_Pay_Valid  = r_pay_valid;
    assign o_Pay_Byte   = r_pay_byte;
    assign o_Pkt_Active = r_active;
    assign o_Pkt_Done   = r_pkt_done;
    assign o_Pkt_Err    = r_pkt_err;
    assign o_Err_Code   = r_err_code;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Bench for uart_rx_packet_ctrl: directed frames from the test plan plus randomized traffic,
// compared every cycle against a frame-level reference model with a queue-based FIFO.
module tb_uart_rx_packet_ctrl;

    localparam int         TO    = 20;
    localparam int         DEPTH = 4;
    localparam int         MAXL  = 16;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic       pay_ready;
    logic       pay_valid;
    logic [7:0] pay_byte;
    logic       pkt_active;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_rx_packet_ctrl #(
        .SYNC_BYTE (SYNC),
        .MAX_LEN   (MAXL),
        .TIMEOUT   (TO),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_Rx_Done   (rx_done),
        .i_Rx_Byte   (rx_byte),
        .o_Pay_Valid (pay_valid),
        .o_Pay_Byte  (pay_byte),
        .i_Pay_Ready (pay_ready),
        .o_Pkt_Active(pkt_active),
        .o_Pkt_Done  (pkt_done),
        .o_Pkt_Err   (pkt_err),
        .o_Err_Code  (err_code)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int n_done_seen, n_err_seen, last_err_cyc, last_byte_cyc;
    logic [1:0] last_code;
    logic [7:0] got_q[$];

    // reference model: frame phase 0..3 = hunt, len, payload, checksum
    int         m_phase, m_rem, m_idle;
    logic [7:0] m_sum;
    logic [7:0] m_q[$];
    logic       e_done, e_err, e_active;
    logic [1:0] e_code;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        m_phase = 0; m_rem = 0; m_idle = 0; m_sum = 8'd0;
        m_q.delete();
        e_done = 1'b0; e_err = 1'b0; e_active = 1'b0; e_code = 2'd0;
    endtask

    task automatic model_update(input logic d, input logic [7:0] b, input logic r);
        logic pop, full;
        pop  = r && (m_q.size() != 0);
        full = (m_q.size() == DEPTH);
        e_done = 1'b0; e_err = 1'b0; e_code = 2'd0;
        if (pop) void'(m_q.pop_front());
        if (d) begin
            m_idle = 0;
            case (m_phase)
                0: if (b == SYNC) m_phase = 1;
                1: begin
                    if (b == 8'd0) begin m_sum = 8'd0; m_phase = 3; end
                    else if (int'(b) > MAXL) begin e_err = 1'b1; e_code = 2'd1; m_phase = 0; end
                    else begin m_sum = b; m_rem = int'(b); m_phase = 2; end
                end
                2: begin
                    if (full && !pop) begin e_err = 1'b1; e_code = 2'd3; m_phase = 0; end
                    else begin
                        m_q.push_back(b);
                        m_sum = m_sum + b;
                        m_rem--;
                        if (m_rem == 0) m_phase = 3;
                    end
                end
                3: begin
                    if (b == m_sum) e_done = 1'b1;
                    else begin e_err = 1'b1; e_code = 2'd0; end
                    m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end else if (m_phase == 0) begin
            m_idle = 0;
        end else if (m_idle == TO - 1) begin
            e_err = 1'b1; e_code = 2'd2; m_phase = 0; m_idle = 0;
        end else begin
            m_idle++;
        end
        e_active = (m_phase != 0);
    endtask

    // One clock: called at a negedge; checks outputs, drives inputs, advances model and clock.
    task automatic step(input logic d, input logic [7:0] b, input logic r);
        check_val("pkt_done", pkt_done, e_done);
        check_val("pkt_err", pkt_err, e_err);
        check_val("err_code", err_code, e_code);
        check_val("pkt_active", pkt_active, e_active);
        check_val("pay_valid", pay_valid, m_q.size() != 0);
        if (m_q.size() != 0) check_val("pay_byte", pay_byte, m_q[0]);
        if (pkt_done) n_done_seen++;
        if (pkt_err) begin n_err_seen++; last_code = err_code; last_err_cyc = cyc; end
        if (pay_valid && r) got_q.push_back(pay_byte);
        rx_done = d; rx_byte = b; pay_ready = r;
        model_update(d, b, r);
        if (d) last_byte_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, r);
    endtask

    task automatic send_seq(input logic [63:0] bytes, input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b1, bytes[8*(n-1-i) +: 8], r);
    endtask

    task automatic check_got(input string tag, input logic [63:0] exp, input int n);
        check_val({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            check_val({tag, "_data"}, got_q[i], exp[8*(n-1-i) +: 8]);
        got_q.delete();
    endtask

    task automatic clear_seen();
        n_done_seen = 0; n_err_seen = 0; last_code = 2'd0; got_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, pay_valid, 1'b0);
        check_val({tag, "_byte"}, pay_byte, 8'd0);
        check_val({tag, "_active"}, pkt_active, 1'b0);
        check_val({tag, "_done"}, pkt_done, 1'b0);
        check_val({tag, "_err"}, pkt_err, 1'b0);
        check_val({tag, "_code"}, err_code, 2'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] frame[$];
        int kind, len, gap;
        logic [7:0] s;
        logic rdy_bias;
        reset_n = 1'b0; rx_done = 1'b0; rx_byte = 8'h00; pay_ready = 1'b0;
        model_reset();
        clear_seen();
        #1;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // good frame, consumer always ready
        clear_seen();
        send_seq(64'hA5_03_11_22_33_69, 6, 1'b1);
        idle(3, 1'b1);
        check_got("good_pay", 64'h11_22_33, 3);
        check_val("good_done_n", n_done_seen, 1);
        check_val("good_err_n", n_err_seen, 0);

        // junk then bad checksum
        clear_seen();
        send_seq(64'h00_7F_A5_02_10_20_31, 7, 1'b1);
        idle(3, 1'b1);
        check_got("badcs_pay", 64'h10_20, 2);
        check_val("badcs_err_n", n_err_seen, 1);
        check_val("badcs_code", last_code, 2'd0);
        check_val("badcs_done_n", n_done_seen, 0);

        // length fault, then zero-length frame
        clear_seen();
        send_seq(64'hA5_11, 2, 1'b1);
        idle(2, 1'b1);
        check_val("len_err_n", n_err_seen, 1);
        check_val("len_code", last_code, 2'd1);
        send_seq(64'hA5_00_00, 3, 1'b1);
        idle(2, 1'b1);
        check_val("zero_done_n", n_done_seen, 1);
        check_got("len_pay", 64'h0, 0);

        // overrun with consumer stalled, then drain
        clear_seen();
        send_seq(64'hA5_06_01_02_03_04_05_06, 8, 1'b0);
        idle(2, 1'b0);
        check_val("ovr_err_n", n_err_seen, 1);
        check_val("ovr_code", last_code, 2'd3);
        idle(6, 1'b1);
        check_got("ovr_pay", 64'h01_02_03_04, 4);

        // timeout after truncated frame
        clear_seen();
        send_seq(64'hA5_04_01, 3, 1'b1);
        idle(TO + 4, 1'b1);
        check_val("tmo_err_n", n_err_seen, 1);
        check_val("tmo_code", last_code, 2'd2);
        check_val("tmo_latency", last_err_cyc - last_byte_cyc, TO + 1);
        check_got("tmo_pay", 64'h01, 1);

        // byte on the terminal cycle suppresses the timeout
        clear_seen();
        send_seq(64'hA5_04_01, 3, 1'b1);
        idle(TO - 1, 1'b1);
        send_seq(64'h02_03_04_0E, 4, 1'b1);
        idle(2, 1'b1);
        check_val("term_err_n", n_err_seen, 0);
        check_val("term_done_n", n_done_seen, 1);
        check_got("term_pay", 64'h01_02_03_04, 4);

        // asynchronous reset mid-payload with two bytes buffered
        clear_seen();
        send_seq(64'hA5_06_11_22, 4, 1'b0);
        check_val("rst_pre_valid", pay_valid, 1'b1);
        check_val("rst_pre_active", pkt_active, 1'b1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        rx_done = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        clear_seen();
        send_seq(64'hA5_02_05_06_0D, 5, 1'b1);
        idle(2, 1'b1);
        check_got("post_rst_pay", 64'h05_06, 2);
        check_val("post_rst_done_n", n_done_seen, 1);

        // randomized traffic against the model
        for (int f = 0; f < 250; f++) begin
            kind = $urandom_range(0, 9);
            rdy_bias = ($urandom_range(0, 3) != 0);
            frame.delete();
            if (kind == 1) frame.push_back(8'($urandom_range(0, 255)));
            frame.push_back(SYNC);
            if (kind == 0) begin
                frame.push_back(8'($urandom_range(MAXL + 1, 255)));
            end else begin
                len = $urandom_range(0, MAXL);
                frame.push_back(8'(len));
                s = 8'(len);
                for (int i = 0; i < len; i++) begin
                    frame.push_back(8'($urandom_range(0, 255)));
                    s = s + frame[frame.size() - 1];
                end
                if (kind == 2) s = s ^ 8'($urandom_range(1, 255));
                if (kind != 3) frame.push_back(s);
            end
            foreach (frame[i]) begin
                gap = ($urandom_range(0, 19) == 0) ? (TO - 2 + $urandom_range(0, 3)) : $urandom_range(0, 2);
                for (int g = 0; g < gap; g++)
                    step(1'b0, 8'($urandom_range(0, 255)), rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
                step(1'b1, frame[i], rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
            end
            if (kind == 3) idle(TO + 2, 1'b1);
        end
        idle(TO + 10, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_packet_ctrl.md
# uart_rx_packet_ctrl

Packet-level receive controller sitting directly downstream of the UART RX byte controller. It consumes the one-cycle `Rx_Done`/byte strobes and hunts for a sync byte. It then sequences the length, payload and checksum fields of a frame, streams payload bytes to the consumer through a small ready/valid FIFO, and reports per-frame completion or error with a fault code. An inter-byte timeout recovers the framer when a frame is truncated on the line.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `MAX_LEN`, default 16: largest legal payload length (1..255).
- `TIMEOUT`, default 1000: clk cycles allowed between bytes inside a frame (≥2).
- `FIFO_DEPTH`, default 4: payload FIFO entries (power of 2, ≥2).
- `clk` input 1: system clock.
- `reset_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `i_Rx_Done` input 1: one-cycle strobe, byte received.
- `i_Rx_Byte` input 8: received byte, valid only while `i_Rx_Done` is high.
- `o_Pay_Valid` output 1: FIFO non-empty.
- `o_Pay_Byte` output 8: FIFO head byte.
- `i_Pay_Ready` input 1: consumer accepts head byte when `o_Pay_Valid & i_Pay_Ready`.
- `o_Pkt_Active` output 1: high in any state other than HUNT.
- `o_Pkt_Done` output 1: one-cycle pulse, frame received with good checksum.
- `o_Pkt_Err` output 1: one-cycle pulse, frame aborted.
- `o_Err_Code` output 2: fault code while `o_Pkt_Err` is high (0 checksum, 1 length, 2 timeout, 3 overrun); 0 otherwise.

## Operation
- The frame format is SYNC, LEN, LEN payload bytes, CSUM.
- CSUM is the 8-bit sum, modulo 256, of LEN and all payload bytes.
- The FSM has four states, and only bytes qualified by `i_Rx_Done` advance it:
  - **HUNT**: a byte equal to `SYNC_BYTE` moves to LEN. Any other byte is dropped silently.
  - **LEN**:
    - A byte of 0 loads `sum=0` and moves to CSUM.
    - A byte greater than `MAX_LEN` pulses error code 1 and returns to HUNT.
    - Otherwise `sum` and `remaining` are loaded with the byte and the state moves to PAYLOAD.
  - **PAYLOAD**:
    - Each byte is pushed to the FIFO, added to `sum`, and decrements `remaining`.
    - When `remaining` reaches 0, the state moves to CSUM.
    - A push that cannot be accepted pulses error code 3, drops the byte, and returns to HUNT.
  - **CSUM**: a byte equal to `sum` pulses `o_Pkt_Done`. A mismatch pulses error code 0. Both cases return to HUNT.
- Timeout counter:
  - Cleared in HUNT and on every `i_Rx_Done`.
  - Otherwise it increments each cycle.
  - Reaching `TIMEOUT` pulses error code 2 and returns to HUNT.
  - If `i_Rx_Done` arrives in the same cycle, it wins: the byte is processed and no timeout fires.
- The FIFO:
  - It is not flushed on abort. Bytes of a failed frame remain and are delivered; the consumer discards them on `o_Pkt_Err`.
  - A push succeeds when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Simultaneous push and pop at any occupancy keeps the count unchanged.
- Reset:
  - Takes effect immediately, including mid-frame.
  - State goes to HUNT and the FIFO is emptied.
  - `o_Pay_Valid`, `o_Pay_Byte`, `o_Pkt_Active`, `o_Pkt_Done`, `o_Pkt_Err` and `o_Err_Code` all go to 0, as do the counters and `sum`.
- Arithmetic:
  - `sum` is 8-bit wrap-around.
  - `remaining` is 8 bits.
  - The timeout counter is `$clog2(TIMEOUT+1)` bits and saturates conceptually at the abort.
  - FIFO pointers are `$clog2(FIFO_DEPTH)` bits wrapping, plus a count register of `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- All outputs are registered.
- Byte processing happens on the edge where `i_Rx_Done` is sampled high; the state change is visible the next cycle.
- `o_Pkt_Done` and `o_Pkt_Err` (with code) are high exactly in the cycle after the deciding `i_Rx_Done`, or the cycle after the counter reaches `TIMEOUT`.
- Push latency: a payload byte appears on `o_Pay_Byte` with `o_Pay_Valid=1` one cycle after its `i_Rx_Done` when the FIFO was empty.
- Pop: on a cycle with `o_Pay_Valid & i_Pay_Ready`, the next head (or `o_Pay_Valid=0`) is presented on the following cycle.
- `o_Pay_Byte` is don't-care while `o_Pay_Valid=0`. It is 0 after reset.
- A new SYNC may be accepted in the cycle immediately after the pulse of the previous frame; back-to-back frames need no gap cycles.
- `o_Pkt_Active` rises the cycle after SYNC is accepted and falls together with the `o_Pkt_Done`/`o_Pkt_Err` pulse.

## Test plan
- Good frame, `i_Pay_Ready=1`: A5,03,11,22,33,69 → payload 11,22,33 streamed in order; `o_Pkt_Done` one cycle after 69; no error.
- Bad checksum and junk: 00,7F,A5,02,10,20,31 → 00 and 7F ignored; 10,20 delivered; `o_Pkt_Err=1`, `o_Err_Code=0` one cycle after 31.
- Length fault and zero length: A5,11 (`MAX_LEN`=16) → error code 1, FIFO untouched. Then A5,00,00 → `o_Pkt_Done`.
- Overrun: `i_Pay_Ready=0`, A5,06 followed by six payload bytes → first 4 bytes buffered; 5th byte gives error code 3. The 6th byte is ignored in HUNT. Raising ready drains exactly 4 bytes.
- Timeout: A5,04,01 then silence → error code 2 exactly `TIMEOUT` cycles after the last `i_Rx_Done`. Also a byte arriving on the terminal cycle suppresses the timeout.
- Reset mid-frame: assert `reset_n=0` during PAYLOAD with 2 bytes buffered → all outputs 0 asynchronously. After release, a complete good frame is received normally.
